dram_stream_writer: RTL and testbench
=====================================

// Module: dram_stream_writer
// PURPOSE
//  AXI3 write master that is the sink of the DRAM stream path. Accepts a config (start addr, byte count),
//  then consumes a 64-bit valid/ready stream and writes it to DRAM as 16-beat x 8-byte (128 B) INCR bursts.
//  Sits downstream of the compute pipeline fed by the DRAM reader. Mirrors the reader's config handshake.
// PARAMETERS
//  MAX_OUTSTANDING  8  max AW bursts issued without a B response (1..15)
// PORTS
//  ACLK            in   1   clock
//  ARESETN         in   1   reset, synchronous, active-low
//  M_AXI_AWADDR    out  32  burst address
//  M_AXI_AWVALID   out  1   addr valid
//  M_AXI_AWREADY   in   1   addr ready
//  M_AXI_AWLEN     out  4   const 4'b1111
//  M_AXI_AWSIZE    out  2   const 2'b11
//  M_AXI_AWBURST   out  2   const 2'b01
//  M_AXI_WDATA     out  64  = DATA
//  M_AXI_WSTRB     out  8   const 8'hFF
//  M_AXI_WVALID    out  1   data valid
//  M_AXI_WREADY    in   1   data ready
//  M_AXI_WLAST     out  1   last beat of burst
//  M_AXI_BVALID    in   1   response valid
//  M_AXI_BREADY    out  1   const 1
//  M_AXI_BRESP     in   2   response code
//  CONFIG_VALID    in   1   start request
//  CONFIG_READY    out  1   writer fully idle
//  CONFIG_START_ADDR in 32  byte address, 128 B aligned
//  CONFIG_NBYTES   in   32  byte count; bits [6:0] ignored
//  DATA_VALID      in   1   upstream beat valid
//  DATA_READY      out  1   beat consumed this cycle
//  DATA            in   64  upstream beat
// BEHAVIOUR
//  - Config accepted when CONFIG_VALID && CONFIG_READY. nbursts = CONFIG_NBYTES[31:7] (25 b).
//  - nbursts==0: accepted as no-op; all FSMs stay IDLE, CONFIG_READY stays 1.
//  - AW FSM IDLE->ISSUE on accept (AWADDR<=START_ADDR, aw_cnt<=nbursts). AWVALID=(ISSUE && outstanding<MAX_OUTSTANDING).
//    On AWVALID&&AWREADY: AWADDR+=128, aw_cnt-=1; ->IDLE when aw_cnt becomes 0. AWADDR wraps mod 2^32.
//  - W FSM IDLE->RUN on accept (w_cnt<=nbursts, beat<=0). WVALID=RUN&&DATA_VALID; DATA_READY=RUN&&WREADY.
//    Beat on WVALID&&WREADY: beat+=1 (4 b, wraps 15->0); WLAST=RUN&&beat==15. On last beat w_cnt-=1; ->IDLE at 0.
//    W may lead AW; no ordering enforced between channels (AXI3 legal).
//  - outstanding (4 b): +1 on AW handshake, -1 on BVALID (BREADY const 1); both same cycle -> unchanged.
//  - CONFIG_READY = AW IDLE && W IDLE && outstanding==0 (asserts only after final B).
//  - CONFIG_VALID while not ready is ignored (no queueing).
//  - Reset: AWADDR=0, AWVALID=0, WVALID=0, WLAST=0, DATA_READY=0, counters=0, FSMs IDLE, CONFIG_READY=1.
//    Reset mid-transfer abandons in-flight bursts; no drain.
//  - Zero latency: DATA -> WDATA combinational; no internal buffering.
// CONFIGURATION
//  DRAM_WRITER_BRESP_CHECK_EN defined: extra output ERR (1 b), sticky; set on BVALID with BRESP!=2'b00;
//    cleared on config accept and reset. Undefined: port ERR absent, BRESP ignored.
// TESTING
//  1 NBYTES=256, addr 0x1000, always-ready slave -> AW 0x1000,0x1080; 32 W beats; WLAST on beats 15,31; READY after 2nd B.
//  2 NBYTES=0x7F -> no AW/W activity; CONFIG_READY stays 1.
//  3 MAX_OUTSTANDING=2, NBYTES=640, B held off -> only 2 AW issued until first BVALID; total 5 AW.
//  4 Random DATA_VALID/WREADY stalls, NBYTES=1024 -> 128 beats in order, data matches, no beat lost/duplicated.
//  5 addr 0xFFFFFF80, NBYTES=256 -> AWADDR 0xFFFFFF80 then 0x00000000.
//  6 ARESETN low mid-burst -> next cycle all valids 0, CONFIG_READY 1; new config runs cleanly (with _EN: BRESP=2 -> ERR=1, cleared on next accept).

Source files
------------

// File: rtl/dram_stream_writer.sv
// AXI3 write master: drains a 64-bit valid/ready stream into DRAM as 16-beat x 8-byte INCR bursts.
// Optional sticky BRESP error flag (ERR port) when DRAM_WRITER_BRESP_CHECK_EN is defined.
module dram_stream_writer #(
  parameter int unsigned MAX_OUTSTANDING = 8
) (
  input  logic        ACLK,
  input  logic        ARESETN,
  output logic [31:0] M_AXI_AWADDR,
  output logic        M_AXI_AWVALID,
  input  logic        M_AXI_AWREADY,
  output logic [3:0]  M_AXI_AWLEN,
  output logic [1:0]  M_AXI_AWSIZE,
  output logic [1:0]  M_AXI_AWBURST,
  output logic [63:0] M_AXI_WDATA,
  output logic [7:0]  M_AXI_WSTRB,
  output logic        M_AXI_WVALID,
  input  logic        M_AXI_WREADY,
  output logic        M_AXI_WLAST,
  input  logic        M_AXI_BVALID,
  output logic        M_AXI_BREADY,
  input  logic [1:0]  M_AXI_BRESP,
  input  logic        CONFIG_VALID,
  output logic        CONFIG_READY,
  input  logic [31:0] CONFIG_START_ADDR,
  input  logic [31:0] CONFIG_NBYTES,
  input  logic        DATA_VALID,
  output logic        DATA_READY,
  input  logic [63:0] DATA
`ifdef DRAM_WRITER_BRESP_CHECK_EN
  ,
  output logic        ERR
`endif
);

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned CNT_W  = 25;
  localparam int unsigned BEAT_W = 4;
  localparam int unsigned OUT_W  = 4;
  localparam logic [ADDR_W-1:0] BURST_BYTES = ADDR_W'(128);
  localparam logic [BEAT_W-1:0] LAST_BEAT   = BEAT_W'(15);

  typedef enum logic {AW_IDLE = 1'b0, AW_ISSUE = 1'b1} aw_state_t;
  typedef enum logic {W_IDLE = 1'b0, W_RUN = 1'b1} w_state_t;

  aw_state_t         r_aw_state, w_aw_state_nxt;
  w_state_t          r_w_state, w_w_state_nxt;
  logic [ADDR_W-1:0] r_awaddr, w_awaddr_nxt;
  logic [CNT_W-1:0]  r_aw_cnt, w_aw_cnt_nxt;
  logic [CNT_W-1:0]  r_w_cnt, w_w_cnt_nxt;
  logic [BEAT_W-1:0] r_beat, w_beat_nxt;
  logic [OUT_W-1:0]  r_outstanding, w_outstanding_nxt;

  logic [CNT_W-1:0]  w_nbursts;
  logic              w_cfg_ready;
  logic              w_cfg_acc;
  logic              w_cfg_go;
  logic              w_awvalid;
  logic              w_aw_hs;
  logic              w_w_run;
  logic              w_w_hs;
  logic              w_last;
  logic              w_unused_ok;

  // Handshake qualifiers; only bursts of 128 B count, low byte-count bits dropped
  assign w_nbursts   = CONFIG_NBYTES[31:7];
  assign w_cfg_ready = (r_aw_state == AW_IDLE) && (r_w_state == W_IDLE) &&
                       (r_outstanding == OUT_W'(0));
  assign w_cfg_acc   = CONFIG_VALID && w_cfg_ready;
  assign w_cfg_go    = w_cfg_acc && (w_nbursts != CNT_W'(0));
  assign w_awvalid   = (r_aw_state == AW_ISSUE) &&
                       (r_outstanding < OUT_W'(MAX_OUTSTANDING));
  assign w_aw_hs     = w_awvalid && M_AXI_AWREADY;
  assign w_w_run     = (r_w_state == W_RUN);
  assign w_w_hs      = w_w_run && DATA_VALID && M_AXI_WREADY;
  assign w_last      = w_w_run && (r_beat == LAST_BEAT);

  // State register
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      r_aw_state    <= AW_IDLE;
      r_w_state     <= W_IDLE;
      r_awaddr      <= '0;
      r_aw_cnt      <= '0;
      r_w_cnt       <= '0;
      r_beat        <= '0;
      r_outstanding <= '0;
    end else begin
      r_aw_state    <= w_aw_state_nxt;
      r_w_state     <= w_w_state_nxt;
      r_awaddr      <= w_awaddr_nxt;
      r_aw_cnt      <= w_aw_cnt_nxt;
      r_w_cnt       <= w_w_cnt_nxt;
      r_beat        <= w_beat_nxt;
      r_outstanding <= w_outstanding_nxt;
    end
  end

  // Next-state logic for the AW and W channel FSMs and the outstanding-burst counter
  always_comb begin
    w_aw_state_nxt    = r_aw_state;
    w_w_state_nxt     = r_w_state;
    w_awaddr_nxt      = r_awaddr;
    w_aw_cnt_nxt      = r_aw_cnt;
    w_w_cnt_nxt       = r_w_cnt;
    w_beat_nxt        = r_beat;
    w_outstanding_nxt = r_outstanding;

    case (r_aw_state)
      AW_IDLE: begin
        if (w_cfg_go) begin
          w_aw_state_nxt = AW_ISSUE;
          w_awaddr_nxt   = CONFIG_START_ADDR;
          w_aw_cnt_nxt   = w_nbursts;
        end
      end
      AW_ISSUE: begin
        if (w_aw_hs) begin
          w_awaddr_nxt = r_awaddr + BURST_BYTES;
          w_aw_cnt_nxt = r_aw_cnt - CNT_W'(1);
          if (r_aw_cnt == CNT_W'(1)) w_aw_state_nxt = AW_IDLE;
        end
      end
      default: w_aw_state_nxt = AW_IDLE;
    endcase

    case (r_w_state)
      W_IDLE: begin
        if (w_cfg_go) begin
          w_w_state_nxt = W_RUN;
          w_w_cnt_nxt   = w_nbursts;
          w_beat_nxt    = '0;
        end
      end
      W_RUN: begin
        if (w_w_hs) begin
          w_beat_nxt = r_beat + BEAT_W'(1);
          if (r_beat == LAST_BEAT) begin
            w_w_cnt_nxt = r_w_cnt - CNT_W'(1);
            if (r_w_cnt == CNT_W'(1)) w_w_state_nxt = W_IDLE;
          end
        end
      end
      default: w_w_state_nxt = W_IDLE;
    endcase

    // A B with nothing in flight (e.g. stale after reset) must not wrap the counter
    if (w_aw_hs && !M_AXI_BVALID) begin
      w_outstanding_nxt = r_outstanding + OUT_W'(1);
    end else if (!w_aw_hs && M_AXI_BVALID && (r_outstanding != OUT_W'(0))) begin
      w_outstanding_nxt = r_outstanding - OUT_W'(1);
    end
  end

`ifdef DRAM_WRITER_BRESP_CHECK_EN
  logic r_err, w_err_nxt;

  // Sticky slave-error flag, cleared on every accepted config
  always_ff @(posedge ACLK) begin
    if (!ARESETN) r_err <= 1'b0;
    else          r_err <= w_err_nxt;
  end

  always_comb begin
    w_err_nxt = r_err;
    if (w_cfg_acc) w_err_nxt = 1'b0;
    if (M_AXI_BVALID && (M_AXI_BRESP != 2'b00)) w_err_nxt = 1'b1;
  end

  assign ERR         = r_err;
  assign w_unused_ok = ^CONFIG_NBYTES[6:0];
`else
  assign w_unused_ok = ^{M_AXI_BRESP, CONFIG_NBYTES[6:0]};
`endif

  assign M_AXI_AWADDR  = r_awaddr;
  assign M_AXI_AWVALID = w_awvalid;
  assign M_AXI_AWLEN   = 4'b1111;
  assign M_AXI_AWSIZE  = 2'b11;
  assign M_AXI_AWBURST = 2'b01;
  assign M_AXI_WDATA   = DATA;
  assign M_AXI_WSTRB   = 8'hFF;
  assign M_AXI_WVALID  = w_w_run && DATA_VALID;
  assign M_AXI_WLAST   = w_last;
  assign M_AXI_BREADY  = 1'b1;
  assign CONFIG_READY  = w_cfg_ready;
  assign DATA_READY    = w_w_run && M_AXI_WREADY;

endmodule

// File: tb/tb_dram_stream_writer.sv
// Scoreboard bench for dram_stream_writer: expected AW addresses and W beats are queued at stimulus time.
// Build with DRAM_WRITER_BRESP_CHECK_EN to also cover the ERR flag.
module tb_dram_stream_writer;

  localparam int unsigned MAX_OUT = 2;

  typedef struct packed {
    logic [63:0] d;
    logic        last;
  } wbeat_t;

  logic        ACLK = 1'b0;
  logic        ARESETN = 1'b0;
  logic [31:0] M_AXI_AWADDR;
  logic        M_AXI_AWVALID;
  logic        M_AXI_AWREADY = 1'b0;
  logic [3:0]  M_AXI_AWLEN;
  logic [1:0]  M_AXI_AWSIZE;
  logic [1:0]  M_AXI_AWBURST;
  logic [63:0] M_AXI_WDATA;
  logic [7:0]  M_AXI_WSTRB;
  logic        M_AXI_WVALID;
  logic        M_AXI_WREADY = 1'b0;
  logic        M_AXI_WLAST;
  logic        M_AXI_BVALID = 1'b0;
  logic        M_AXI_BREADY;
  logic [1:0]  M_AXI_BRESP = 2'b00;
  logic        CONFIG_VALID = 1'b0;
  logic        CONFIG_READY;
  logic [31:0] CONFIG_START_ADDR = '0;
  logic [31:0] CONFIG_NBYTES = '0;
  logic        DATA_VALID = 1'b0;
  logic        DATA_READY;
  logic [63:0] DATA = '0;
`ifdef DRAM_WRITER_BRESP_CHECK_EN
  logic        ERR;
`endif

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] q_aw[$];
  wbeat_t      q_w[$];
  int aw_done = 0, wl_done = 0, b_sent = 0;
  int aw_base = 0, b_base = 0;
  bit rnd = 0, b_hold = 0;
  logic [1:0] bresp_val = 2'b00;
  int m_done;

  dram_stream_writer #(.MAX_OUTSTANDING(MAX_OUT)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
    .M_AXI_AWLEN(M_AXI_AWLEN), .M_AXI_AWSIZE(M_AXI_AWSIZE), .M_AXI_AWBURST(M_AXI_AWBURST),
    .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB), .M_AXI_WVALID(M_AXI_WVALID),
    .M_AXI_WREADY(M_AXI_WREADY), .M_AXI_WLAST(M_AXI_WLAST),
    .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BREADY(M_AXI_BREADY), .M_AXI_BRESP(M_AXI_BRESP),
    .CONFIG_VALID(CONFIG_VALID), .CONFIG_READY(CONFIG_READY),
    .CONFIG_START_ADDR(CONFIG_START_ADDR), .CONFIG_NBYTES(CONFIG_NBYTES),
    .DATA_VALID(DATA_VALID), .DATA_READY(DATA_READY), .DATA(DATA)
`ifdef DRAM_WRITER_BRESP_CHECK_EN
    , .ERR(ERR)
`endif
  );

  always #5 ACLK = ~ACLK;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Channel monitor: handshakes sampled mid-cycle, popped against the scoreboard
  always @(negedge ACLK) begin
    if (!ARESETN) begin
      aw_done = 0;
      wl_done = 0;
    end else begin
      if (M_AXI_AWVALID && M_AXI_AWREADY) begin
        aw_done++;
        chk("aw_attrs", 64'({M_AXI_AWLEN, M_AXI_AWSIZE, M_AXI_AWBURST}), 64'({4'hF, 2'b11, 2'b01}));
        if (q_aw.size() == 0) chk("aw_extra", 64'(q_aw.size()), 64'd1);
        else                  chk("awaddr", 64'(M_AXI_AWADDR), 64'(q_aw.pop_front()));
      end
      if (M_AXI_WVALID && M_AXI_WREADY) begin
        if (M_AXI_WLAST) wl_done++;
        chk("wstrb", 64'(M_AXI_WSTRB), 64'hFF);
        if (q_w.size() == 0) begin
          chk("w_extra", 64'(q_w.size()), 64'd1);
        end else begin
          wbeat_t e;
          e = q_w.pop_front();
          chk("wdata", M_AXI_WDATA, e.d);
          chk("wlast", 64'(M_AXI_WLAST), 64'(e.last));
        end
      end
    end
  end

  // Slave model: ready generation and one B per burst that has both AW and WLAST done
  always begin
    @(posedge ACLK);
    #1;
    if (!ARESETN) begin
      M_AXI_AWREADY = 1'b0;
      M_AXI_WREADY  = 1'b0;
      M_AXI_BVALID  = 1'b0;
      b_sent        = 0;
    end else begin
      if (M_AXI_BVALID) b_sent++;
      M_AXI_AWREADY = rnd ? ($urandom_range(0, 99) < 60) : 1'b1;
      M_AXI_WREADY  = rnd ? ($urandom_range(0, 99) < 60) : 1'b1;
      m_done = (aw_done < wl_done) ? aw_done : wl_done;
      M_AXI_BVALID  = !b_hold && (m_done > b_sent) && (rnd ? ($urandom_range(0, 99) < 50) : 1'b1);
      M_AXI_BRESP   = bresp_val;
    end
  end

  task automatic do_config(input logic [31:0] addr, input logic [31:0] nbytes);
    logic [24:0] nb;
    logic [31:0] a;
    nb = nbytes[31:7];
    b_base  = b_sent;
    aw_base = aw_done;
    for (int k = 0; k < int'(nb); k++) begin
      a = addr + 32'(k * 128);
      q_aw.push_back(a);
    end
    CONFIG_START_ADDR = addr;
    CONFIG_NBYTES     = nbytes;
    CONFIG_VALID      = 1'b1;
    @(negedge ACLK);
    chk("cfg_ready_at_accept", 64'(CONFIG_READY), 64'd1);
    @(posedge ACLK);
    #1;
    CONFIG_VALID = 1'b0;
  endtask

  task automatic send_stream(input int nbeats, input bit stall);
    for (int i = 0; i < nbeats; i++) begin
      wbeat_t e;
      bit took;
      int budget;
      e.d    = {$urandom, $urandom};
      e.last = ((i % 16) == 15);
      q_w.push_back(e);
      DATA   = e.d;
      took   = 1'b0;
      budget = 0;
      while (!took && budget < 200) begin
        DATA_VALID = stall ? ($urandom_range(0, 99) < 70) : 1'b1;
        @(negedge ACLK);
        took = DATA_VALID && DATA_READY;
        @(posedge ACLK);
        #1;
        budget++;
      end
      if (!took) begin
        chk("stream_timeout", 64'(i), 64'(nbeats));
        DATA_VALID = 1'b0;
        return;
      end
    end
    DATA_VALID = 1'b0;
  endtask

  task automatic wait_idle(input int exp_b);
    int cyc;
    cyc = 0;
    @(negedge ACLK);
    while (!CONFIG_READY && cyc < 3000) begin
      @(negedge ACLK);
      cyc++;
    end
    chk("idle_reached", 64'(CONFIG_READY), 64'd1);
    chk("b_count_at_ready", 64'(b_sent - b_base), 64'(exp_b));
    chk("aw_queue_empty", 64'(q_aw.size()), 64'd0);
    chk("w_queue_empty", 64'(q_w.size()), 64'd0);
    @(posedge ACLK);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int act;
    repeat (4) @(posedge ACLK);
    #1;
    ARESETN = 1'b1;
    @(negedge ACLK);
    chk("rst_cfg_ready", 64'(CONFIG_READY), 64'd1);
    chk("rst_awvalid", 64'(M_AXI_AWVALID), 64'd0);
    chk("rst_awaddr", 64'(M_AXI_AWADDR), 64'd0);
    chk("rst_wvalid", 64'(M_AXI_WVALID), 64'd0);
    chk("rst_wlast", 64'(M_AXI_WLAST), 64'd0);
    chk("rst_data_ready", 64'(DATA_READY), 64'd0);
    chk("rst_bready", 64'(M_AXI_BREADY), 64'd1);
    @(posedge ACLK);
    #1;

    // Two bursts from 0x1000 with an always-ready slave
    do_config(32'h0000_1000, 32'd256);
    send_stream(32, 1'b0);
    wait_idle(2);
    chk("t1_aw_count", 64'(aw_done - aw_base), 64'd2);
`ifdef DRAM_WRITER_BRESP_CHECK_EN
    chk("t1_err_clean", 64'(ERR), 64'd0);
`endif

    // Sub-burst byte count is a no-op
    do_config(32'h0000_2000, 32'h0000_007F);
    act = 0;
    DATA_VALID = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge ACLK);
      if (DATA_READY || M_AXI_WVALID || M_AXI_AWVALID || !CONFIG_READY) act++;
      @(posedge ACLK);
      #1;
    end
    DATA_VALID = 1'b0;
    chk("t2_no_activity", 64'(act), 64'd0);
    chk("t2_cfg_ready", 64'(CONFIG_READY), 64'd1);

    // Outstanding limit with B held off
    b_hold = 1'b1;
    do_config(32'h0000_2000, 32'd640);
    send_stream(80, 1'b0);
    repeat (20) @(posedge ACLK);
    #1;
    chk("t3_aw_limited", 64'(aw_done - aw_base), 64'(MAX_OUT));
    chk("t3_cfg_busy", 64'(CONFIG_READY), 64'd0);
    b_hold = 1'b0;
    wait_idle(5);
    chk("t3_aw_total", 64'(aw_done - aw_base), 64'd5);

    // Random stalls on both sides
    rnd = 1'b1;
    do_config(32'h0004_0000, 32'd1024);
    send_stream(128, 1'b1);
    wait_idle(8);
    rnd = 1'b0;

    // Address wrap past 4 GiB
    do_config(32'hFFFF_FF80, 32'd256);
    send_stream(32, 1'b0);
    wait_idle(2);

    // Reset mid-transfer, then a clean run
    b_hold = 1'b1;
    do_config(32'h0000_3000, 32'd512);
    send_stream(20, 1'b0);
    ARESETN    = 1'b0;
    DATA_VALID = 1'b1;
    @(posedge ACLK);
    #1;
    @(negedge ACLK);
    chk("t6_awvalid", 64'(M_AXI_AWVALID), 64'd0);
    chk("t6_wvalid", 64'(M_AXI_WVALID), 64'd0);
    chk("t6_wlast", 64'(M_AXI_WLAST), 64'd0);
    chk("t6_data_ready", 64'(DATA_READY), 64'd0);
    chk("t6_cfg_ready", 64'(CONFIG_READY), 64'd1);
    q_aw.delete();
    q_w.delete();
    @(posedge ACLK);
    #1;
    ARESETN    = 1'b1;
    DATA_VALID = 1'b0;
    b_hold     = 1'b0;
    bresp_val  = 2'b10;
    @(posedge ACLK);
    #1;
    do_config(32'h0000_5000, 32'd256);
    send_stream(32, 1'b0);
    wait_idle(2);
    bresp_val = 2'b00;
`ifdef DRAM_WRITER_BRESP_CHECK_EN
    chk("t6_err_set", 64'(ERR), 64'd1);
    do_config(32'h0000_6000, 32'd0);
    @(negedge ACLK);
    chk("t6_err_cleared", 64'(ERR), 64'd0);
    @(posedge ACLK);
    #1;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
